// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage driving the IF/ID register over a req/ack imem handshake.
// Optional stall-cycle counter: define FETCH_PERF_CNT_EN to add perf_stall_cnt.
module instr_fetch_unit #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'hF800_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_en,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    outPC,
    output logic [INSTR_WIDTH-1:0] outInstruction,
    output logic                   outValid
`ifdef FETCH_PERF_CNT_EN
    ,output logic [15:0]           perf_stall_cnt
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]             r_state;
    logic                   r_req;
    logic [PC_WIDTH-1:0]    r_addr;
    logic [PC_WIDTH-1:0]    r_out_pc;
    logic [INSTR_WIDTH-1:0] r_out_instr;
    logic                   r_out_valid;
    logic [INSTR_WIDTH-1:0] r_hold_instr;
    logic [PC_WIDTH-1:0]    r_hold_pc;
    logic [PC_WIDTH-1:0]    r_target;
    logic [PC_WIDTH-1:0]    w_next_pc;

    assign w_next_pc      = r_addr + 1'b1;
    assign imem_req       = r_req;
    assign imem_addr      = r_addr;
    assign outPC          = r_out_pc;
    assign outInstruction = r_out_instr;
    assign outValid       = r_out_valid;

    // Fetch FSM: request issue, response presentation, stall buffering and redirect/drop handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_out_pc     <= '0;
            r_out_instr  <= NOP_INSTR;
            r_out_valid  <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_target     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req   <= 1'b1;
                    r_addr  <= redirect_en ? redirect_pc : RESET_PC;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (redirect_en) begin
                        r_out_instr  <= NOP_INSTR;
                        r_out_valid  <= 1'b0;
                        r_hold_instr <= '0;
                        r_hold_pc    <= '0;
                        if (imem_ack) begin
                            r_addr <= redirect_pc;
                        end else begin
                            r_target <= redirect_pc;
                            r_state  <= S_DROP;
                        end
                    end else if (imem_ack && !stall) begin
                        r_out_instr <= imem_rdata;
                        r_out_pc    <= w_next_pc;
                        r_out_valid <= 1'b1;
                        r_addr      <= w_next_pc;
                    end else if (imem_ack) begin
                        r_hold_instr <= imem_rdata;
                        r_hold_pc    <= w_next_pc;
                        r_req        <= 1'b0;
                        r_state      <= S_HOLD;
                    end else if (!stall) begin
                        r_out_instr <= NOP_INSTR;
                        r_out_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect_en) begin
                        r_out_instr  <= NOP_INSTR;
                        r_out_valid  <= 1'b0;
                        r_hold_instr <= '0;
                        r_hold_pc    <= '0;
                        r_req        <= 1'b1;
                        r_addr       <= redirect_pc;
                        r_state      <= S_WAIT;
                    end else if (!stall) begin
                        r_out_instr <= r_hold_instr;
                        r_out_pc    <= r_hold_pc;
                        r_out_valid <= 1'b1;
                        r_req       <= 1'b1;
                        r_addr      <= r_hold_pc;
                        r_state     <= S_WAIT;
                    end
                end
                S_DROP: begin
                    r_out_instr <= NOP_INSTR;
                    r_out_valid <= 1'b0;
                    if (redirect_en) r_target <= redirect_pc;
                    if (imem_ack) begin
                        r_addr  <= redirect_en ? redirect_pc : r_target;
                        r_state <= S_WAIT;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf_cnt;
    assign perf_stall_cnt = r_perf_cnt;

    // Saturating count of clock edges seen with stall asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_perf_cnt <= '0;
        else if (stall && r_perf_cnt != 16'hFFFF) r_perf_cnt <= r_perf_cnt + 1'b1;
    end
`endif
endmodule
